// File: rtl/xosera_bus_if_pkg.sv
// Shared bus-interface types and polarity constants for the Xosera host bus.
package xv;

  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_QUAL,
    BUS_RD_ACK,
    BUS_RD_HOLD,
    BUS_WR_HOLD
  } bus_state_t;

  localparam logic cs_ENABLED = 1'b0;
  localparam logic RnW_READ   = 1'b1;

  localparam int unsigned BUS_DATA_W = 8;
  localparam int unsigned BUS_REG_W  = 4;

endpackage

// File: rtl/xosera_sync_ff.sv
// Multi-stage synchroniser for an input group, with a per-bit reset value.
module xosera_sync_ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) r_pipe[i] <= RESET_VAL;
    end else begin
      r_pipe[0] <= i_d;
      for (int unsigned i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[STAGES-1];

endmodule

// File: rtl/xosera_bus_if.sv
// Host-bus front end: synchronises the async pad bus, filters chip select and
// turns each access into a single read or write strobe for xosera_main.
module xosera_bus_if
  import xv::*;
#(
  parameter int unsigned DATA_W        = BUS_DATA_W,
  parameter int unsigned REG_W         = BUS_REG_W,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 1,
  parameter int unsigned OE_MODE       = 0
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              bus_cs_n_i,
  input  logic              bus_rd_nwr_i,
  input  logic              bus_bytesel_i,
  input  logic [REG_W-1:0]  bus_reg_num_i,
  input  logic [DATA_W-1:0] bus_data_i,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              bus_out_ena_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              rd_strobe_o,
  output logic              wr_strobe_o,
  output logic [REG_W-1:0]  reg_num_o,
  output logic              bytesel_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o
);

  localparam int unsigned CTRL_W = REG_W + 3;
  localparam logic [2:0]  FILT   = 3'(FILTER_CYCLES);

  logic [CTRL_W-1:0] w_ctrl_sync;
  logic [DATA_W-1:0] w_data_sync;
  logic              w_cs_n;
  logic              w_rd_nwr;
  logic              w_bytesel;
  logic [REG_W-1:0]  w_reg_num;
  logic              w_cs_act;

  // Control and data share the same depth so captured data lines up with CS.
  xosera_sync_ff #(
    .WIDTH    (CTRL_W),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL({~cs_ENABLED, RnW_READ, 1'b0, {REG_W{1'b0}}})
  ) u_sync_ctrl (
    .i_clk  (clk),
    .i_rst_n(reset_n_i),
    .i_d    ({bus_cs_n_i, bus_rd_nwr_i, bus_bytesel_i, bus_reg_num_i}),
    .o_q    (w_ctrl_sync)
  );

  xosera_sync_ff #(
    .WIDTH    (DATA_W),
    .STAGES   (SYNC_STAGES),
    .RESET_VAL({DATA_W{1'b0}})
  ) u_sync_data (
    .i_clk  (clk),
    .i_rst_n(reset_n_i),
    .i_d    (bus_data_i),
    .o_q    (w_data_sync)
  );

  assign {w_cs_n, w_rd_nwr, w_bytesel, w_reg_num} = w_ctrl_sync;
  assign w_cs_act = (w_cs_n == cs_ENABLED);

  bus_state_t        r_state;
  bus_state_t        w_state_nx;
  logic              w_qualify;
  logic              w_is_read;
  logic [2:0]        r_filt_cnt;
  logic              r_rd_strobe;
  logic              r_wr_strobe;
  logic [REG_W-1:0]  r_reg_num;
  logic              r_bytesel;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_bus_data;
  logic              r_oe;

  assign w_is_read = (w_rd_nwr == RnW_READ);

  always_comb begin
    w_state_nx = r_state;
    w_qualify  = 1'b0;
    case (r_state)
      BUS_IDLE: if (w_cs_act) w_state_nx = BUS_QUAL;
      BUS_QUAL: begin
        if (!w_cs_act) begin
          w_state_nx = BUS_IDLE;
        end else if (r_filt_cnt == FILT) begin
          w_qualify  = 1'b1;
          w_state_nx = w_is_read ? BUS_RD_ACK : BUS_WR_HOLD;
        end
      end
      // Stays two cycles: the strobe cycle, then the cycle rd_data_i is valid.
      BUS_RD_ACK:  if (!r_rd_strobe) w_state_nx = BUS_RD_HOLD;
      BUS_RD_HOLD,
      BUS_WR_HOLD: if (!w_cs_act) w_state_nx = BUS_IDLE;
      default:     w_state_nx = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= BUS_IDLE;
      r_filt_cnt  <= '0;
      r_rd_strobe <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_reg_num   <= '0;
      r_bytesel   <= 1'b0;
      r_wr_data   <= '0;
      r_bus_data  <= '0;
      r_oe        <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_rd_strobe <= w_qualify & w_is_read;
      r_wr_strobe <= w_qualify & ~w_is_read;
      r_oe        <= (w_state_nx == BUS_RD_HOLD);

      if (!w_cs_act) begin
        r_filt_cnt <= '0;
      end else if ((r_state == BUS_IDLE || r_state == BUS_QUAL) && r_filt_cnt != FILT) begin
        r_filt_cnt <= r_filt_cnt + 3'd1;
      end

      if (w_qualify) begin
        r_reg_num <= w_reg_num;
        r_bytesel <= w_bytesel;
        r_wr_data <= w_data_sync;
      end

      if (r_state == BUS_RD_ACK && !r_rd_strobe) r_bus_data <= rd_data_i;
    end
  end

  generate
    if (OE_MODE == 0) begin : g_oe_raw
      assign bus_out_ena_o = reset_n_i & (bus_cs_n_i == cs_ENABLED) & (bus_rd_nwr_i == RnW_READ);
    end else begin : g_oe_reg
      assign bus_out_ena_o = reset_n_i & r_oe;
    end
  endgenerate

  assign bus_data_o  = r_bus_data;
  assign rd_strobe_o = r_rd_strobe;
  assign wr_strobe_o = r_wr_strobe;
  assign reg_num_o   = r_reg_num;
  assign bytesel_o   = r_bytesel;
  assign wr_data_o   = r_wr_data;
  assign busy_o      = (r_state != BUS_IDLE);

endmodule

// File: tb/tb_xosera_bus_if.sv
// Scoreboard bench: two instances (8-bit/raw OE/filter 1 and 16-bit/registered OE/filter 3).
module tb_xosera_bus_if;

  localparam int unsigned A_LAT = 2 + 1 + 1;
  localparam int unsigned B_LAT = 2 + 3 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        cs_n = 1'b1;
  logic        rd_nwr = 1'b1;
  logic        bs = 1'b0;
  logic [5:0]  rg = '0;
  logic [15:0] din = '0;
  logic [15:0] rdd = 16'hDEAD;

  always #5 clk = ~clk;

  logic        a_cs_n, b_cs_n;
  logic [7:0]  a_bd, a_wd;
  logic [3:0]  a_reg;
  logic        a_oe, a_rs, a_ws, a_bs, a_busy;
  logic [15:0] b_bd, b_wd;
  logic [5:0]  b_reg;
  logic        b_oe, b_rs, b_ws, b_bs, b_busy;

  assign a_cs_n = sel ? 1'b1 : cs_n;
  assign b_cs_n = sel ? cs_n : 1'b1;

  xosera_bus_if #(.DATA_W(8), .REG_W(4), .SYNC_STAGES(2), .FILTER_CYCLES(1), .OE_MODE(0)) dut_a (
    .clk(clk), .reset_n_i(rst_n), .bus_cs_n_i(a_cs_n), .bus_rd_nwr_i(rd_nwr),
    .bus_bytesel_i(bs), .bus_reg_num_i(rg[3:0]), .bus_data_i(din[7:0]),
    .bus_data_o(a_bd), .bus_out_ena_o(a_oe), .rd_data_i(rdd[7:0]),
    .rd_strobe_o(a_rs), .wr_strobe_o(a_ws), .reg_num_o(a_reg), .bytesel_o(a_bs),
    .wr_data_o(a_wd), .busy_o(a_busy));

  xosera_bus_if #(.DATA_W(16), .REG_W(6), .SYNC_STAGES(2), .FILTER_CYCLES(3), .OE_MODE(1)) dut_b (
    .clk(clk), .reset_n_i(rst_n), .bus_cs_n_i(b_cs_n), .bus_rd_nwr_i(rd_nwr),
    .bus_bytesel_i(bs), .bus_reg_num_i(rg), .bus_data_i(din),
    .bus_data_o(b_bd), .bus_out_ena_o(b_oe), .rd_data_i(rdd),
    .rd_strobe_o(b_rs), .wr_strobe_o(b_ws), .reg_num_o(b_reg), .bytesel_o(b_bs),
    .wr_data_o(b_wd), .busy_o(b_busy));

  logic        m_ws, m_rs, m_oe, m_bs, m_busy;
  logic [5:0]  m_reg;
  logic [15:0] m_wd, m_bd;
  assign m_ws   = sel ? b_ws : a_ws;
  assign m_rs   = sel ? b_rs : a_rs;
  assign m_oe   = sel ? b_oe : a_oe;
  assign m_bs   = sel ? b_bs : a_bs;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_reg  = sel ? b_reg : {2'b00, a_reg};
  assign m_wd   = sel ? b_wd : {8'h00, a_wd};
  assign m_bd   = sel ? b_bd : {8'h00, a_bd};

  typedef struct {
    bit          rd;
    logic [5:0]  rg;
    logic        bs;
    logic [15:0] d;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned rd_step = 0;
  logic [15:0] rd_val = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  task automatic push_exp(input bit rd, input logic [5:0] r, input logic b, input logic [15:0] d);
    exp_t e;
    e.rd  = rd;
    e.rg  = sel ? r : {2'b00, r[3:0]};
    e.bs  = b;
    e.d   = sel ? d : {8'h00, d[7:0]};
    e.cyc = cyc + (sel ? B_LAT : A_LAT);
    sb.push_back(e);
  endtask

  // Register-file model: supply read data only in the cycle after the strobe.
  always @(posedge clk) begin
    #1;
    if (rd_step == 1) begin
      rdd     = rd_val;
      rd_step = 2;
    end else if (rd_step == 2) begin
      rdd     = 16'hDEAD;
      rd_step = 3;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rd_step == 2) check("oe_rd_ack", m_oe, sel ? 1'b0 : 1'b1);
    if (rd_step == 3) begin
      check("rd_bus_data", m_bd, rd_val);
      check("oe_rd_hold", m_oe, 1'b1);
      rd_step = 0;
    end
    if (m_ws || m_rs) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {m_rs, m_ws}, 2'b00);
      end else begin
        e = sb.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_rd", m_rs, e.rd);
        check("strobe_wr", m_ws, !e.rd);
        check("reg_num", m_reg, e.rg);
        check("bytesel", m_bs, e.bs);
        if (e.rd) begin
          rd_val  = e.d;
          rd_step = 1;
        end else begin
          check("wr_data", m_wd, e.d);
        end
      end
    end
  end

  task automatic access(input bit rd, input logic [5:0] r, input logic b, input logic [15:0] d,
                        input int unsigned low, input int unsigned high);
    @(negedge clk);
    cs_n = 1'b0; rd_nwr = rd; rg = r; bs = b; din = d;
    push_exp(rd, r, b, d);
    if (!sel) begin
      #1 check("oe_raw_assert", a_oe, rd);
    end
    repeat (low) @(negedge clk);
    if (rd) check("rd_data_held", m_bd, sel ? d : {8'h00, d[7:0]});
    cs_n = 1'b1; rd_nwr = 1'b1;
    if (rd) begin
      #1 check("oe_after_cs_rise", m_oe, sel ? 1'b1 : 1'b0);
    end
    repeat (high) @(negedge clk);
    if (high >= 4) begin
      check("busy_idle", m_busy, 1'b0);
      check("oe_idle", m_oe, 1'b0);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_a"}, {a_ws, a_rs, a_busy, a_oe, a_bs, a_reg, a_wd, a_bd}, '0);
    check({tag, "_b_ctl"}, {b_ws, b_rs, b_busy, b_oe, b_bs, b_reg}, '0);
    check({tag, "_b_data"}, {b_wd, b_bd}, '0);
  endtask

  initial begin
    // Reset with a raw read cycle on the pins: OE must still be low.
    cs_n = 1'b0; rd_nwr = 1'b1;
    #1 check("oe_in_reset", a_oe, 1'b0);
    check_cleared("reset");
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    access(1'b0, 6'h05, 1'b1, 16'h00A7, 6, 4);
    access(1'b1, 6'h02, 1'b0, 16'h003C, 8, 4);

    // Late changes to rd_nwr/reg_num while holding must not re-trigger or recapture.
    @(negedge clk);
    cs_n = 1'b0; rd_nwr = 1'b0; rg = 6'h03; bs = 1'b0; din = 16'h0011;
    push_exp(1'b0, 6'h03, 1'b0, 16'h0011);
    repeat (6) @(negedge clk);
    rg = 6'h0F; rd_nwr = 1'b1; din = 16'h00FF;
    repeat (4) @(negedge clk);
    check("hold_reg", a_reg, 4'h3);
    check("hold_wdata", a_wd, 8'h11);
    check("hold_busy", a_busy, 1'b1);
    cs_n = 1'b1; rd_nwr = 1'b1;
    repeat (4) @(negedge clk);

    access(1'b0, 6'h01, 1'b0, 16'h0055, 6, 2);
    access(1'b0, 6'h02, 1'b1, 16'h0066, 6, 4);

    // Reset mid-access with CS held low, then a fresh access after release.
    @(negedge clk);
    cs_n = 1'b0; rd_nwr = 1'b0; rg = 6'h09; bs = 1'b0; din = 16'h0077;
    push_exp(1'b0, 6'h09, 1'b0, 16'h0077);
    repeat (6) @(negedge clk);
    check("pre_reset_busy", a_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_cleared("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(1'b0, 6'h09, 1'b0, 16'h0077);
    repeat (7) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);

    sel = 1'b1;
    repeat (2) @(negedge clk);
    // Short CS glitch is rejected by the 3-sample filter.
    cs_n = 1'b0; rd_nwr = 1'b0; rg = 6'h07;
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("glitch_busy", b_busy, 1'b0);

    access(1'b0, 6'h05, 1'b0, 16'h0F0F, 8, 4);
    access(1'b0, 6'h2A, 1'b0, 16'hBEEF, 8, 4);
    access(1'b1, 6'h11, 1'b1, 16'h1234, 10, 5);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xosera_bus_if.md
Name: xosera_bus_if

Overview:
Parametrised host-bus interface between the board pads and xosera_main. It supersedes the fixed 8-bit, purely combinational tri-state split done in each board top.
- Synchronises the asynchronous m68k-style bus (cs_n, rd_nwr, bytesel, reg_num, data) into the pixel-clock domain.
- Glitch-filters chip select.
- Emits single-cycle read/write strobes with captured register number, byte select and write data.
- Drives read data and output enable for the pad tri-state buffers, with a selectable OE mode.

Parameters:
DATA_W, 8, bus data width (8 or 16).
REG_W, 4, register-number width (3..6).
SYNC_STAGES, 2, synchroniser flops per bus input (2..4).
FILTER_CYCLES, 1, consecutive synced-asserted CS samples needed to qualify an access (1..7).
OE_MODE, 0, 0 = output enable combinational from raw pins (fast turn-on); 1 = output enable from synchronised, qualified state.

Ports:
clk  in  1  pixel clock.
reset_n_i  in  1  reset, asynchronous, active-low.
bus_cs_n_i  in  1  raw chip select, active low.
bus_rd_nwr_i  in  1  raw read (1) / write (0).
bus_bytesel_i  in  1  raw even (0) / odd (1) byte select.
bus_reg_num_i  in  REG_W  raw register number.
bus_data_i  in  DATA_W  raw data from pads.
bus_data_o  out  DATA_W  read data to pads.
bus_out_ena_o  out  1  pad output enable.
rd_data_i  in  DATA_W  register-file read data, valid the cycle after rd_strobe_o.
rd_strobe_o  out  1  one-cycle read request.
wr_strobe_o  out  1  one-cycle write request.
reg_num_o  out  REG_W  captured register number.
bytesel_o  out  1  captured byte select.
wr_data_o  out  DATA_W  captured write data.
busy_o  out  1  access in progress (any state other than IDLE).

Behaviour:
- Reset state: all outputs 0, state IDLE, filter counter 0, synchronisers preset to the inactive values cs_n = 1, rd_nwr = 1.
- bus_out_ena_o is forced 0 while reset_n_i = 0, in both OE modes.
- Synchronisation:
  - All bus inputs, including data, pass through identical SYNC_STAGES pipelines built from xosera_sync_ff.
  - Synced data is therefore aligned with synced control.
- Filter counter:
  - Increments while synced CS is asserted and the state is IDLE or QUAL, saturating at FILTER_CYCLES.
  - Clears to 0 on any synced CS deassert.
- States: IDLE, QUAL, RD_ACK, RD_HOLD, WR_HOLD.
- IDLE -> QUAL on synced CS asserted.
- QUAL:
  - On the counter reaching FILTER_CYCLES, capture reg_num_o, bytesel_o and wr_data_o from the synced inputs.
  - If synced rd_nwr = 1: go to RD_ACK and pulse rd_strobe_o for 1 cycle.
  - Otherwise: go to WR_HOLD and pulse wr_strobe_o for 1 cycle.
  - If synced CS deasserts before qualification: return to IDLE with no strobe and no capture.
- Latency: counting the first clk edge that samples raw CS low as edge 1, the strobe is high in the cycle after edge SYNC_STAGES + FILTER_CYCLES + 1.
- RD_ACK: register rd_data_i into bus_data_o, then go to RD_HOLD.
- RD_HOLD and WR_HOLD:
  - bus_data_o and the captured outputs hold.
  - Go to IDLE on synced CS deassert.
  - Exactly one strobe per CS assertion, regardless of hold length.
- rd_nwr or reg_num changing after qualification is ignored until the next access.
- OE_MODE 0: bus_out_ena_o = reset_n_i & ~bus_cs_n_i & bus_rd_nwr_i (raw pins, no clock).
- OE_MODE 1: bus_out_ena_o is registered, set on entry to RD_HOLD, cleared on exit to IDLE.
- Back-to-back accesses: a new CS assertion seen in the same cycle as the transition to IDLE enters QUAL on the next edge. No assertion is lost as long as CS is high for at least 1 synced sample.
- Asynchronous reset mid-access:
  - State immediately returns to IDLE and outputs clear.
  - A strobe in flight is cancelled.
  - After reset release, a still-asserted CS is treated as a new access.

Decomposition:
- xv package:
  - bus_state_t enum (the five states).
  - Existing cs_ENABLED and RnW_READ constants, reused for polarity.
  - BUS_DATA_W and BUS_REG_W defaults.
- Sub-module: xosera_sync_ff.
  - Parameters WIDTH, STAGES, RESET_VAL.
  - Asynchronous active-low reset.
  - Instantiated once per input group.
- Pad SB_IO instances stay in board tops; this block only supplies bus_data_o and bus_out_ena_o.

Test Plan:
1. Write (DATA_W = 8, SYNC_STAGES = 2, FILTER_CYCLES = 1): CS low 6 cycles, rd_nwr = 0, reg = 4'h5, bytesel = 1, data = 8'hA7 -> wr_strobe_o high for exactly 1 cycle after edge 4, reg_num_o = 5, bytesel_o = 1, wr_data_o = A7, rd_strobe_o stays 0.
2. Read: CS low, rd_nwr = 1, reg = 4'h2, rd_data_i = 8'h3C on the cycle after the strobe -> rd_strobe_o 1 cycle, bus_data_o = 3C one cycle later, held until CS rises. OE_MODE 0: bus_out_ena_o follows the raw pins. OE_MODE 1: bus_out_ena_o is high from RD_HOLD entry to IDLE.
3. Glitch (FILTER_CYCLES = 3): CS low 2 cycles then high -> no strobe, busy_o returns to 0. CS low 8 cycles -> exactly one strobe.
4. Back-to-back: two writes (regs 1 then 2) with CS high for 2 cycles between them -> two wr_strobe_o pulses, correct regs, no merge.
5. Reset mid-access: assert reset_n_i = 0 while in WR_HOLD with CS still low -> all outputs 0 immediately. On release, one new strobe after the full latency.
6. DATA_W = 16, REG_W = 6: write 16'hBEEF to reg 6'h2A -> wr_data_o = BEEF, reg_num_o = 2A.
